biquad_cascade_sequencer: RTL and testbench

- Time-multiplexed biquad engine. One shared signed multiply-accumulate unit evaluates SECTIONS cascaded second-order sections per audio sample.
- Replaces per-band instantiation of parallel filter hardware in the equalizer bands (e.g. high-pass followed by low-pass to form a band-pass).
- Sequences coefficient fetch, MAC, round/saturate and state update from a sample strobe.
- Coefficients are runtime-writable through a simple write port.

---
 rtl/biquad_seq_pkg.sv | 57 +++++
 rtl/biquad_mac_unit.sv | 55 +++++
 rtl/biquad_cascade_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_biquad_cascade_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biquad_seq_pkg.sv
// Shared constants, FSM encoding and the round/saturate helper for the
// time-multiplexed biquad cascade.
package biquad_seq_pkg;

    localparam int DECIM        = 14;
    localparam int MAGN         = 8;
    localparam int N            = DECIM + MAGN + 1;
    localparam int SECTIONS_DEF = 2;
    localparam int ACC_W        = 2 * N + 3;
    localparam int TAPS         = 5;

    // Coefficient slot within a section; a1/a2 are stored pre-negated.
    localparam int K_B0 = 0;
    localparam int K_B1 = 1;
    localparam int K_B2 = 2;
    localparam int K_A1 = 3;
    localparam int K_A2 = 4;

    // Unity gain in Q(MAGN).(DECIM): the passthrough value of b0.
    localparam logic [N-1:0] ONE = N'(1 << DECIM);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    typedef struct packed {
        logic [N-1:0] value;
        logic         sat;
    } round_sat_t;

    // Round half-up at the DECIM boundary, then clip to the N-bit signed range.
    function automatic round_sat_t round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] biased;
        logic signed [ACC_W:0] shifted;
        logic signed [ACC_W:0] max_v;
        logic signed [ACC_W:0] min_v;
        round_sat_t            res;
        max_v   = (ACC_W + 1)'((1 << (N - 1)) - 1);
        min_v   = ~max_v;
        biased  = {acc[ACC_W-1], acc};
        biased  = biased + (ACC_W + 1)'(1 << (DECIM - 1));
        shifted = biased >>> DECIM;
        res.sat = 1'b1;
        if (shifted > max_v) begin
            res.value = max_v[N-1:0];
        end else if (shifted < min_v) begin
            res.value = min_v[N-1:0];
        end else begin
            res.value = shifted[N-1:0];
            res.sat   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/biquad_mac_unit.sv
// Shared signed MAC: registered product, clearable accumulator, and a
// combinational rounded/saturated view of (accumulator + pending product).
module biquad_mac_unit
    import biquad_seq_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         mul_en,
    input  logic         acc_clr,
    input  logic         acc_en,
    input  logic [N-1:0] coef,
    input  logic [N-1:0] operand,
    output logic [N-1:0] result,
    output logic         result_sat
);

    logic signed [2*N-1:0]   prod_q, prod_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] total;
    round_sat_t              rs;

    // Next product and next accumulator value.
    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        prod_d   = prod_q;
        acc_d    = acc_q;
        prod_ext = ACC_W'(prod_q);
        if (mul_en) begin
            prod_d = (2 * N)'($signed(coef)) * (2 * N)'($signed(operand));
        end
        if (acc_clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + prod_ext;
        end
        total      = acc_q + prod_ext;
        rs         = round_sat(total);
        result     = rs.value;
        result_sat = rs.sat;
    end

    // Product and accumulator registers.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/biquad_cascade_sequencer.sv
// Time-multiplexed cascade of biquad sections sharing one MAC. Each sample
// takes 5 MAC cycles plus one write-back cycle per section.
module biquad_cascade_sequencer
    import biquad_seq_pkg::*;
#(
    parameter int SECTIONS = SECTIONS_DEF
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              gen_enable,
    input  logic [N-1:0]                      data_in,
    output logic [N-1:0]                      data_out,
    output logic                              data_valid,
    output logic                              busy,
    input  logic                              coef_we,
    input  logic [$clog2(5*SECTIONS)-1:0]     coef_addr,
    input  logic [N-1:0]                      coef_wdata,
    output logic                              sat_flag,
    output logic                              overrun
);

    localparam int NCOEF = TAPS * SECTIONS;
    localparam int CW    = $clog2(NCOEF);
    localparam int SW    = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;

    state_e          state_q, state_d;
    logic [SW-1:0]   sec_q, sec_d;
    logic [2:0]      k_q, k_d;
    logic [N-1:0]    x_cur_q, x_cur_d;
    logic [N-1:0]    coef_q [NCOEF];
    logic [N-1:0]    coef_d [NCOEF];
    logic [N-1:0]    x1_q [SECTIONS];
    logic [N-1:0]    x1_d [SECTIONS];
    logic [N-1:0]    x2_q [SECTIONS];
    logic [N-1:0]    x2_d [SECTIONS];
    logic [N-1:0]    y1_q [SECTIONS];
    logic [N-1:0]    y1_d [SECTIONS];
    logic [N-1:0]    y2_q [SECTIONS];
    logic [N-1:0]    y2_d [SECTIONS];
    logic [N-1:0]    data_out_q, data_out_d;
    logic            data_valid_q, data_valid_d;
    logic            sat_q, sat_d;
    logic            ovr_q, ovr_d;

    logic [CW-1:0]   coef_idx;
    logic [N-1:0]    mac_coef;
    logic [N-1:0]    mac_operand;
    logic            mul_en, acc_clr, acc_en;
    logic [N-1:0]    mac_result;
    logic            mac_sat;

    // Select the coefficient and operand for the current tap.
    always_comb begin
        coef_idx = CW'(int'(sec_q) * TAPS + int'(k_q));
        mac_coef = coef_q[coef_idx];
        case (int'(k_q))
            K_B0:    mac_operand = x_cur_q;
            K_B1:    mac_operand = x1_q[sec_q];
            K_B2:    mac_operand = x2_q[sec_q];
            K_A1:    mac_operand = y1_q[sec_q];
            K_A2:    mac_operand = y2_q[sec_q];
            default: mac_operand = '0;
        endcase
    end

    biquad_mac_unit u_mac (
        .clock      (clock),
        .reset      (reset),
        .mul_en     (mul_en),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .coef       (mac_coef),
        .operand    (mac_operand),
        .result     (mac_result),
        .result_sat (mac_sat)
    );

    // Sequencer: next state, coefficient writes, section state update, flags.
    always_comb begin
        state_d      = state_q;
        sec_d        = sec_q;
        k_d          = k_q;
        x_cur_d      = x_cur_q;
        coef_d       = coef_q;
        x1_d         = x1_q;
        x2_d         = x2_q;
        y1_d         = y1_q;
        y2_d         = y2_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        sat_d        = sat_q;
        ovr_d        = ovr_q;
        mul_en       = 1'b0;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A write in the same cycle as the strobe lands before the first MAC read.
                if (coef_we && (int'(coef_addr) < NCOEF)) begin
                    coef_d[coef_addr] = coef_wdata;
                end
                if (gen_enable) begin
                    x_cur_d = data_in;
                    sec_d   = '0;
                    k_d     = '0;
                    state_d = ST_MAC;
                end
            end

            ST_MAC: begin
                // Tap 0 starts a fresh sum; later taps add the product registered one cycle earlier.
                mul_en  = 1'b1;
                acc_clr = (k_q == 3'd0);
                acc_en  = (k_q != 3'd0);
                if (int'(k_q) == K_A2) begin
                    state_d = ST_WB;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end

            ST_WB: begin
                x2_d[sec_q] = x1_q[sec_q];
                x1_d[sec_q] = x_cur_q;
                y2_d[sec_q] = y1_q[sec_q];
                y1_d[sec_q] = mac_result;
                x_cur_d     = mac_result;
                if (mac_sat) begin
                    sat_d = 1'b1;
                end
                if (int'(sec_q) == SECTIONS - 1) begin
                    data_out_d   = mac_result;
                    data_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    sec_d   = sec_q + SW'(1);
                    k_d     = '0;
                    state_d = ST_MAC;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Strobes arriving mid-sample are dropped and remembered.
        if ((state_q != ST_IDLE) && (gen_enable || coef_we)) begin
            ovr_d = 1'b1;
        end
    end

    // All sequencer state, coefficient file and per-section history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            sec_q        <= '0;
            k_q          <= '0;
            x_cur_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            sat_q        <= 1'b0;
            ovr_q        <= 1'b0;
            // NOTE: the coefficient file is a small flop array, not a RAM, so it can and must reset to passthrough.
            for (int i = 0; i < NCOEF; i++) begin
                coef_q[i] <= ((i % TAPS) == K_B0) ? ONE : '0;
            end
            x1_q <= '{default: '0};
            x2_q <= '{default: '0};
            y1_q <= '{default: '0};
            y2_q <= '{default: '0};
        end else begin
            state_q      <= state_d;
            sec_q        <= sec_d;
            k_q          <= k_d;
            x_cur_q      <= x_cur_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            sat_q        <= sat_d;
            ovr_q        <= ovr_d;
            coef_q       <= coef_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            y1_q         <= y1_d;
            y2_q         <= y2_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign sat_flag   = sat_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_biquad_cascade_sequencer.sv
// Scoreboard bench: the driver pushes expected outputs from a plain-arithmetic
// cascade model; an independent monitor pops them when data_valid fires.
module tb_biquad_cascade_sequencer;
    import biquad_seq_pkg::*;

    localparam int SEC = 2;
    localparam int NC  = 5 * SEC;
    localparam int LAT = 6 * SEC + 1;
    localparam int AW  = $clog2(NC);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          gen_enable = 1'b0;
    logic          coef_we = 1'b0;
    logic [N-1:0]  data_in = '0;
    logic [N-1:0]  coef_wdata = '0;
    logic [AW-1:0] coef_addr = '0;
    logic [N-1:0]  data_out;
    logic          data_valid, busy, sat_flag, overrun;

    biquad_cascade_sequencer #(.SECTIONS(SEC)) dut (
        .clock      (clock),
        .reset      (reset),
        .gen_enable (gen_enable),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .sat_flag   (sat_flag),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] value;
        int           due;
        logic         sat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: whole-number arithmetic on the difference equation.
    longint m_coef [NC];
    longint m_x1 [SEC];
    longint m_x2 [SEC];
    longint m_y1 [SEC];
    longint m_y2 [SEC];
    bit     m_sat, m_ovr;
    int     m_free, busy_lo, busy_hi;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint sx(input logic [N-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) m_coef[i] = ((i % 5) == 0) ? (longint'(1) << DECIM) : 0;
        for (int s = 0; s < SEC; s++) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
        m_sat = 0; m_ovr = 0; m_free = 0; busy_lo = 1; busy_hi = 0;
        sb_q.delete();
    endfunction

    function automatic logic [N-1:0] model_sample(input logic [N-1:0] din);
        longint x, acc, r, maxv, minv;
        maxv = (longint'(1) << (N - 1)) - 1;
        minv = -(longint'(1) << (N - 1));
        x = sx(din);
        for (int s = 0; s < SEC; s++) begin
            acc = m_coef[5*s] * x + m_coef[5*s+1] * m_x1[s] + m_coef[5*s+2] * m_x2[s]
                + m_coef[5*s+3] * m_y1[s] + m_coef[5*s+4] * m_y2[s];
            r = (acc + (longint'(1) << (DECIM - 1))) >>> DECIM;
            if (r > maxv) begin r = maxv; m_sat = 1; end
            else if (r < minv) begin r = minv; m_sat = 1; end
            m_x2[s] = m_x1[s]; m_x1[s] = x;
            m_y2[s] = m_y1[s]; m_y1[s] = r;
            x = r;
        end
        return x[N-1:0];
    endfunction

    function automatic void model_step(input logic ge, input logic [N-1:0] din,
                                       input logic we, input logic [AW-1:0] addr,
                                       input logic [N-1:0] wd);
        exp_t e;
        bit   idle;
        idle = (cyc >= m_free);
        if (we) begin
            if (idle) m_coef[addr] = sx(wd);
            else      m_ovr = 1;
        end
        if (ge) begin
            if (idle) begin
                e.value = model_sample(din);
                e.due   = cyc + LAT;
                e.sat   = m_sat;
                sb_q.push_back(e);
                m_free  = cyc + LAT;
                busy_lo = cyc + 1;
                busy_hi = cyc + LAT - 1;
            end else begin
                m_ovr = 1;
            end
        end
    endfunction

    // Called at a falling edge; holds the strobes for exactly one cycle.
    task automatic drive(input logic ge, input logic [N-1:0] din, input logic we,
                         input logic [AW-1:0] addr, input logic [N-1:0] wd);
        gen_enable = ge; data_in = din; coef_we = we; coef_addr = addr; coef_wdata = wd;
        model_step(ge, din, we, addr, wd);
        @(negedge clock);
        gen_enable = 1'b0; coef_we = 1'b0;
    endtask

    task automatic wcoef(input int addr, input logic [N-1:0] wd);
        drive(1'b0, '0, 1'b1, AW'(addr), wd);
    endtask

    task automatic wait_idle();
        while (cyc <= m_free) @(negedge clock);
    endtask

    task automatic sample_check(input string name, input logic [N-1:0] din, input logic [N-1:0] exp);
        wait_idle();
        drive(1'b1, din, 1'b0, '0, '0);
        wait_idle();
        check(name, data_out, exp);
    endtask

    // Called at a falling edge; asserts reset off-edge and checks the reset state.
    task automatic apply_reset();
        #2;
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Monitor: busy window every cycle, and output/timing/sat on each data_valid.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) begin
            check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
            if (data_valid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_valid: data_out=0x%0h with no sample pending (cycle %0d)", data_out, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("data_out", data_out, e.value);
                    check("valid_cycle", cyc, e.due);
                    check("sat_flag", sat_flag, e.sat);
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL missed_valid: no data_valid, required at cycle %0d (now %0d)", sb_q[0].due, cyc);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic          ge, we;
        logic [N-1:0]  din, wd;
        int            addr, v;

        model_reset();
        apply_reset();

        // Default coefficients pass the sample through both sections.
        sample_check("passthru", 23'h001000, 23'h001000);

        // Back-to-back samples, the next one accepted in the data_valid cycle.
        for (int i = 0; i < 3; i++) begin
            while (cyc < m_free) @(negedge clock);
            drive(1'b1, N'($urandom_range(0, 32'h7FFFF)), 1'b0, '0, '0);
        end
        wait_idle();

        // FIR with rounding.
        apply_reset();
        wcoef(0, 23'h002000);
        wcoef(1, 23'h002000);
        sample_check("fir_0", 23'h004000, 23'h002000);
        sample_check("fir_1", 23'h000000, 23'h002000);
        sample_check("fir_2", 23'h000000, 23'h000000);
        sample_check("fir_round", 23'h000001, 23'h000001);

        // First-order feedback decay.
        apply_reset();
        wcoef(0, 23'h004000);
        wcoef(3, 23'h002000);
        sample_check("fb_0", 23'h004000, 23'h004000);
        sample_check("fb_1", 23'h000000, 23'h002000);
        sample_check("fb_2", 23'h000000, 23'h001000);
        sample_check("fb_3", 23'h000000, 23'h000800);

        // Saturation in both directions.
        apply_reset();
        wcoef(0, 23'h020000);
        sample_check("sat_pos", 23'h200000, 23'h3FFFFF);
        check("sat_flag_set", sat_flag, 1);
        sample_check("sat_neg", 23'h600000, 23'h400000);

        // Second strobe mid-sample is ignored and flagged.
        apply_reset();
        drive(1'b1, 23'h001000, 1'b0, '0, '0);
        repeat (4) @(negedge clock);
        drive(1'b1, 23'h003000, 1'b0, '0, '0);
        wait_idle();
        check("ovr_gen_out", data_out, 23'h001000);
        check("ovr_gen_flag", overrun, 1);

        // Coefficient write mid-sample is dropped.
        apply_reset();
        drive(1'b1, 23'h001000, 1'b0, '0, '0);
        repeat (2) @(negedge clock);
        wcoef(0, 23'h000000);
        wait_idle();
        sample_check("ovr_coef_out", 23'h001000, 23'h001000);
        check("ovr_coef_flag", overrun, 1);

        // Reset mid-sample aborts and restores default coefficients.
        apply_reset();
        wcoef(0, 23'h002000);
        drive(1'b1, 23'h001000, 1'b0, '0, '0);
        repeat (6) @(negedge clock);
        apply_reset();
        sample_check("post_abort", 23'h001000, 23'h001000);

        // Randomized traffic, including strobes and writes while busy.
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            ge   = ($urandom_range(0, 2) != 0);
            we   = ($urandom_range(0, 3) == 0);
            addr = $urandom_range(0, NC - 1);
            v    = int'($urandom_range(0, 32767)) - 16384;
            wd   = N'(v);
            if ($urandom_range(0, 3) == 0) begin
                din = N'($urandom);
            end else begin
                v   = int'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
                din = N'(v);
            end
            drive(ge, din, we, AW'(addr), wd);
            repeat ($urandom_range(0, 7)) @(negedge clock);
        end
        wait_idle();
        check("sb_drained", sb_q.size(), 0);
        check("final_overrun", overrun, m_ovr);
        check("final_sat_flag", sat_flag, m_sat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
